// File: rtl/sram_async_fsm_controller.sv
// ============================================================================
// Module   : sram_async_fsm_controller
// Purpose  : FSM-sequenced controller for an asynchronous SRAM (512Kx8
//            default). Accepts single-word read/write requests on a
//            valid/ready handshake and produces registered, glitch-free
//            ce_n/oe_n/we_n/address/data timing with programmable wait
//            states and a bus-turnaround gap after every access.
// Ports    : clk, reset          - clock, async active-high reset
//            req, rw, addr,
//            data_f2s            - request side (sampled when ready=1)
//            ready               - controller idle, request accepted
//            rd_valid,
//            data_s2f_r          - one-cycle read strobe + held read data
//            ad, we_n, oe_n,
//            ce_n, dio           - SRAM pins
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_async_fsm_controller #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int RD_CYCLES   = 2,
  parameter int WR_CYCLES   = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_f2s,
  output logic              ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] data_s2f_r,
  output logic [ADDR_W-1:0] ad,
  output logic              we_n,
  output logic              oe_n,
  output logic              ce_n,
  inout  wire  [DATA_W-1:0] dio
);

  localparam int MAX_RW  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int MAX_CYC = (MAX_RW > TURN_CYCLES) ? MAX_RW : TURN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counter reload values: a phase of N cycles loads N-1 and exits at 0.
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam logic             HAS_TURN  = (TURN_CYCLES > 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_WHOLD = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata;
  logic              drive;

  assign ready = (state == S_IDLE);

  // Bus is driven only from WRITE entry until WHOLD exit, so the data hold
  // extends one full cycle past the we_n rising edge.
  assign dio = drive ? wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ce_n       <= 1'b1;
      oe_n       <= 1'b1;
      we_n       <= 1'b1;
      ad         <= '0;
      wdata      <= '0;
      drive      <= 1'b0;
      rd_valid   <= 1'b0;
      data_s2f_r <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            ad    <= addr;
            wdata <= data_f2s;
            ce_n  <= 1'b0;
            if (rw) begin
              state <= S_READ;
              cnt   <= RD_LOAD;
              oe_n  <= 1'b0;
            end else begin
              state <= S_WRITE;
              cnt   <= WR_LOAD;
              we_n  <= 1'b0;
              drive <= 1'b1;
            end
          end
        end

        S_READ: begin
          if (cnt == '0) begin
            data_s2f_r <= dio;
            rd_valid   <= 1'b1;
            ce_n       <= 1'b1;
            oe_n       <= 1'b1;
            if (HAS_TURN) begin
              state <= S_TURN;
              cnt   <= TURN_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_WRITE: begin
          if (cnt == '0) begin
            we_n  <= 1'b1;
            state <= S_WHOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_WHOLD: begin
          ce_n  <= 1'b1;
          drive <= 1'b0;
          if (HAS_TURN) begin
            state <= S_TURN;
            cnt   <= TURN_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end

        S_TURN: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          ce_n  <= 1'b1;
          oe_n  <= 1'b1;
          we_n  <= 1'b1;
          drive <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_async_fsm_controller.sv
// ============================================================================
// Module   : tb_sram_async_fsm_controller
// Purpose  : Directed self-checking bench for sram_async_fsm_controller.
//            Instance u_dut uses default parameters with a full 512Kx8 SRAM
//            model; u_dut2 uses RD=1/WR=3/TURN=0 with a 256-byte model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_async_fsm_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- default-parameter instance ----------------
  logic        req, rw, ready, rd_valid, we_n, oe_n, ce_n;
  logic [18:0] addr, ad;
  logic [7:0]  data_f2s, data_s2f_r;
  wire  [7:0]  dio;
  logic [7:0]  mem [0:(1<<19)-1];

  sram_async_fsm_controller u_dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr),
    .data_f2s(data_f2s), .ready(ready), .rd_valid(rd_valid),
    .data_s2f_r(data_s2f_r), .ad(ad), .we_n(we_n), .oe_n(oe_n),
    .ce_n(ce_n), .dio(dio)
  );

  assign dio = (!ce_n && !oe_n && we_n) ? mem[ad] : 8'bz;
  always @(posedge clk) if (!ce_n && !we_n) mem[ad] <= dio;

  // ---------------- swept-parameter instance ----------------
  logic        req2, rw2, ready2, rd_valid2, we_n2, oe_n2, ce_n2;
  logic [18:0] addr2, ad2;
  logic [7:0]  wdat2, rdat2;
  wire  [7:0]  dio2;
  logic [7:0]  mem2 [0:255];

  sram_async_fsm_controller #(.RD_CYCLES(1), .WR_CYCLES(3), .TURN_CYCLES(0)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .rw(rw2), .addr(addr2),
    .data_f2s(wdat2), .ready(ready2), .rd_valid(rd_valid2),
    .data_s2f_r(rdat2), .ad(ad2), .we_n(we_n2), .oe_n(oe_n2),
    .ce_n(ce_n2), .dio(dio2)
  );

  assign dio2 = (!ce_n2 && !oe_n2 && we_n2) ? mem2[ad2[7:0]] : 8'bz;
  always @(posedge clk) if (!ce_n2 && !we_n2) mem2[ad2[7:0]] <= dio2;

  // we_n and oe_n must never be low together (bus contention guard)
  int excl_err = 0;
  always @(negedge clk) begin
    if (!we_n && !oe_n)   excl_err <= excl_err + 1;
    if (!we_n2 && !oe_n2) excl_err <= excl_err + 1;
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 100) begin
      tick();
      k++;
    end
    check("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  // One complete access on u_dut; returns read data captured at rd_valid.
  task automatic access(input logic r, input logic [18:0] a, input logic [7:0] d,
                        output logic [7:0] q);
    int k = 0;
    q = 8'h00;
    wait_ready();
    req = 1'b1; rw = r; addr = a; data_f2s = d;
    tick();
    req = 1'b0;
    while (!ready && k < 50) begin
      if (rd_valid) q = data_s2f_r;
      tick();
      k++;
    end
    if (rd_valid) q = data_s2f_r;
    check("access_done", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] q;
    int i, j, k, t0, t1;
    logic acc;

    reset = 1'b1;
    req = 0; rw = 0; addr = '0; data_f2s = '0;
    req2 = 0; rw2 = 0; addr2 = '0; wdat2 = '0;
    #1;
    check("rst_ce_n", {31'd0, ce_n}, 1);
    check("rst_oe_n", {31'd0, oe_n}, 1);
    check("rst_we_n", {31'd0, we_n}, 1);
    check("rst_ready", {31'd0, ready}, 1);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_ad", {13'd0, ad}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // ---- single write, defaults ----
    req = 1; rw = 0; addr = 19'h1_2345; data_f2s = 8'hA5;
    tick(); req = 0;                                   // E+1
    check("wr1_we_n", {31'd0, we_n}, 0);
    check("wr1_ce_n", {31'd0, ce_n}, 0);
    check("wr1_oe_n", {31'd0, oe_n}, 1);
    check("wr1_ad", {13'd0, ad}, 32'h1_2345);
    check("wr1_dio", {24'd0, dio}, 32'hA5);
    check("wr1_ready", {31'd0, ready}, 0);
    tick();                                            // E+2
    check("wr2_we_n", {31'd0, we_n}, 0);
    check("wr2_ad", {13'd0, ad}, 32'h1_2345);
    tick();                                            // E+3 WHOLD
    check("whold_we_n", {31'd0, we_n}, 1);
    check("whold_ce_n", {31'd0, ce_n}, 0);
    check("whold_dio", {24'd0, dio}, 32'hA5);
    check("whold_ad", {13'd0, ad}, 32'h1_2345);
    tick();                                            // E+4 TURN
    check("turn_ce_n", {31'd0, ce_n}, 1);
    check("turn_ready", {31'd0, ready}, 0);
    tick();                                            // E+5
    check("wr_ready_e5", {31'd0, ready}, 1);
    check("wr_mem", {24'd0, mem[19'h1_2345]}, 32'hA5);

    // ---- single read, defaults ----
    req = 1; rw = 1; addr = 19'h1_2345;
    tick(); req = 0;                                   // E+1
    check("rd1_ce_n", {31'd0, ce_n}, 0);
    check("rd1_oe_n", {31'd0, oe_n}, 0);
    check("rd1_we_n", {31'd0, we_n}, 1);
    check("rd1_valid", {31'd0, rd_valid}, 0);
    tick();                                            // E+2
    check("rd2_valid", {31'd0, rd_valid}, 0);
    tick();                                            // E+3
    check("rd3_valid", {31'd0, rd_valid}, 1);
    check("rd3_data", {24'd0, data_s2f_r}, 32'hA5);
    check("rd3_oe_n", {31'd0, oe_n}, 1);
    check("rd3_ready", {31'd0, ready}, 0);
    tick();                                            // E+4
    check("rd4_valid", {31'd0, rd_valid}, 0);
    check("rd4_ready", {31'd0, ready}, 1);
    check("rd4_hold", {24'd0, data_s2f_r}, 32'hA5);

    // ---- handshake: req pulse while busy is ignored ----
    access(1'b0, 19'd200, 8'h33, q);
    req = 1; rw = 0; addr = 19'd100; data_f2s = 8'h77;
    tick(); req = 0;                                   // E+1
    tick();                                            // E+2 busy
    check("hs_busy", {31'd0, ready}, 0);
    req = 1; rw = 0; addr = 19'd200; data_f2s = 8'h11;
    tick(); req = 0;
    wait_ready();
    tick(); tick();
    check("hs_idle_ce_n", {31'd0, ce_n}, 1);
    check("hs_no_write", {24'd0, mem[200]}, 32'h33);

    // ---- handshake: req held during TURN accepted in first IDLE ----
    req = 1; rw = 0; addr = 19'd300; data_f2s = 8'h44;
    tick(); req = 0;                                   // E+1
    tick(); tick(); tick();                            // E+4 TURN
    check("ht_turn", {31'd0, ready}, 0);
    req = 1; rw = 1; addr = 19'd300;
    tick();                                            // E+5 IDLE
    check("ht_idle", {31'd0, ready}, 1);
    tick();                                            // E+6 READ
    req = 0;
    check("ht_ce_n", {31'd0, ce_n}, 0);
    check("ht_oe_n", {31'd0, oe_n}, 0);
    k = 0; q = 8'h00;
    while (!ready && k < 50) begin
      if (rd_valid) q = data_s2f_r;
      tick(); k++;
    end
    check("ht_data", {24'd0, q}, 32'h44);

    // ---- reset mid-write ----
    req = 1; rw = 0; addr = 19'd400; data_f2s = 8'h99;
    tick(); req = 0;
    check("rstw_we_n_low", {31'd0, we_n}, 0);
    #1 reset = 1'b1;
    #1;
    check("rstw_ce_n", {31'd0, ce_n}, 1);
    check("rstw_we_n", {31'd0, we_n}, 1);
    check("rstw_oe_n", {31'd0, oe_n}, 1);
    check("rstw_ready", {31'd0, ready}, 1);
    check("rstw_data", {24'd0, data_s2f_r}, 0);
    tick();
    reset = 1'b0;
    tick();

    // ---- back-to-back writes 0..255, req held high ----
    i = 0; k = 0; t0 = 0; t1 = 0;
    req = 1; rw = 0; addr = 19'd0; data_f2s = 8'd0;
    while (i < 256 && k < 3000) begin
      acc = ready;
      tick(); k++;
      if (acc) begin
        if (i == 0)   t0 = k;
        if (i == 255) t1 = k;
        i++;
        addr = 19'(i); data_f2s = 8'(i);
      end
    end
    req = 0;
    check("b2b_wr_count", i, 256);
    check("b2b_wr_period", t1 - t0, 255 * 5);

    // ---- back-to-back reads ----
    wait_ready();
    i = 0; j = 0; k = 0;
    req = 1; rw = 1; addr = 19'd0;
    while (j < 256 && k < 3000) begin
      if (rd_valid) begin
        check("b2b_rd", {24'd0, data_s2f_r}, 32'(j[7:0]));
        j++;
      end
      acc = ready;
      tick(); k++;
      if (acc && req) begin
        i++;
        if (i == 256) req = 0;
        addr = 19'(i);
      end
    end
    req = 0;
    check("b2b_rd_count", j, 256);

    // ---- boundary addresses ----
    access(1'b0, 19'h0, 8'h00, q);
    access(1'b0, 19'h7_FFFF, 8'hFF, q);
    access(1'b1, 19'h0, 8'h5A, q);
    check("bnd_lo", {24'd0, q}, 32'h00);
    access(1'b1, 19'h7_FFFF, 8'h5A, q);
    check("bnd_hi", {24'd0, q}, 32'hFF);

    // ---- parameter sweep instance: write ----
    check("p_ready0", {31'd0, ready2}, 1);
    req2 = 1; rw2 = 0; addr2 = 19'd5; wdat2 = 8'h3C;
    tick(); req2 = 0;                                  // E+1
    check("p_we1", {31'd0, we_n2}, 0);
    tick();
    check("p_we2", {31'd0, we_n2}, 0);
    tick();
    check("p_we3", {31'd0, we_n2}, 0);
    check("p_wr_busy", {31'd0, ready2}, 0);
    tick();                                            // E+4 WHOLD
    check("p_whold_we", {31'd0, we_n2}, 1);
    check("p_whold_ce", {31'd0, ce_n2}, 0);
    check("p_whold_dio", {24'd0, dio2}, 32'h3C);
    check("p_whold_rdy", {31'd0, ready2}, 0);
    tick();                                            // E+5
    check("p_wr_ready", {31'd0, ready2}, 1);
    check("p_wr_ce", {31'd0, ce_n2}, 1);
    check("p_mem", {24'd0, mem2[5]}, 32'h3C);

    // ---- parameter sweep instance: read ----
    req2 = 1; rw2 = 1; addr2 = 19'd5;
    tick(); req2 = 0;                                  // E+1
    check("p_rd1_oe", {31'd0, oe_n2}, 0);
    check("p_rd1_valid", {31'd0, rd_valid2}, 0);
    check("p_rd1_ready", {31'd0, ready2}, 0);
    tick();                                            // E+2
    check("p_rd2_valid", {31'd0, rd_valid2}, 1);
    check("p_rd2_data", {24'd0, rdat2}, 32'h3C);
    check("p_rd2_ready", {31'd0, ready2}, 1);
    tick();
    check("p_rd3_valid", {31'd0, rd_valid2}, 0);

    check("we_oe_exclusive", excl_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
